// File: rtl/gba_bus_pkg.sv
// rtl/gba_bus_pkg.sv - shared types and helpers for the GBA system-bus arbiter
package gba_bus_pkg;

  localparam int NUM_DMA_CH = 4;

  typedef enum logic [1:0] {
    CPU_OWN  = 2'd0,
    HANDOFF  = 2'd1,
    DMA_XFER = 2'd2,
    RETURN   = 2'd3
  } arb_state_t;

  typedef logic [1:0] dma_ch_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        write;
  } bus_req_t;

  function automatic logic [NUM_DMA_CH-1:0] ch_onehot(input dma_ch_t ch);
    return 4'b0001 << ch;
  endfunction

endpackage

// File: rtl/gba_bus_arbiter_prio_enc.sv
// rtl/gba_bus_arbiter_prio_enc.sv - lowest-index-wins DMA request encoder with exclude mask
module dma_prio_enc
  import gba_bus_pkg::*;
(
  input  logic [NUM_DMA_CH-1:0] req_i,
  input  logic [NUM_DMA_CH-1:0] excl_i,
  output logic                  valid_o,
  output dma_ch_t               ch_o
);

  logic [NUM_DMA_CH-1:0] masked;

  assign masked  = req_i & ~excl_i;
  assign valid_o = |masked;

  // Scan from the top so the lowest set index is written last and wins.
  always_comb begin
    ch_o = '0;
    for (int i = NUM_DMA_CH - 1; i >= 0; i--) begin
      if (masked[i]) ch_o = dma_ch_t'(i);
    end
  end

endmodule

// File: rtl/gba_bus_arbiter.sv
// rtl/gba_bus_arbiter.sv - fixed-priority owner of the shared bus between the CPU and four DMA channels
module gba_bus_arbiter
  import gba_bus_pkg::*;
#(
  parameter int unsigned HANDOFF_CYCLES = 2,
  parameter int unsigned RETURN_CYCLES  = 2,
  parameter int unsigned PREEMPT        = 1,
  parameter int unsigned CPU_SLOT       = 0
) (
  input  logic                        clk,
  input  logic                        rst_b,
  input  logic [31:0]                 cpu_addr,
  input  logic [31:0]                 cpu_wdata,
  input  logic [1:0]                  cpu_size,
  input  logic                        cpu_write,
  input  logic                        cpu_lock,
  input  logic [NUM_DMA_CH-1:0]       dma_req,
  input  logic [NUM_DMA_CH-1:0]       dma_last,
  input  logic [NUM_DMA_CH-1:0][31:0] dma_addr,
  input  logic [NUM_DMA_CH-1:0][31:0] dma_wdata,
  input  logic [NUM_DMA_CH-1:0][1:0]  dma_size,
  input  logic [NUM_DMA_CH-1:0]       dma_write,
  input  logic                        bus_pause,
  output logic [31:0]                 bus_addr,
  output logic [31:0]                 bus_wdata,
  output logic [1:0]                  bus_size,
  output logic                        bus_write,
  output logic                        bus_valid,
  output logic [NUM_DMA_CH-1:0]       dma_grant,
  output logic                        cpu_stall,
  output logic                        dma_active,
  output logic [15:0]                 dma_beats
);

  localparam logic [7:0]  HCNT_INIT = 8'(HANDOFF_CYCLES - 1);
  localparam logic [7:0]  RCNT_INIT = 8'(RETURN_CYCLES - 1);
  localparam logic [15:0] SLOT_LEN  = 16'(CPU_SLOT);

  arb_state_t            state_q, state_d;
  dma_ch_t               ch_q, ch_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [15:0]           beats_q, beats_d;
  logic [NUM_DMA_CH-1:0] grant_q, grant_d;

  logic                  any_valid, rel_valid;
  dma_ch_t               any_ch, rel_ch;
  logic [NUM_DMA_CH-1:0] higher_mask;
  logic [15:0]           beat_inc;
  bus_req_t              sel;

  dma_prio_enc u_enc_any (
    .req_i   (dma_req),
    .excl_i  ('0),
    .valid_o (any_valid),
    .ch_o    (any_ch)
  );

  // Release arbitration: the channel finishing this beat cannot re-win it.
  dma_prio_enc u_enc_rel (
    .req_i   (dma_req),
    .excl_i  (ch_onehot(ch_q)),
    .valid_o (rel_valid),
    .ch_o    (rel_ch)
  );

  assign higher_mask = ch_onehot(ch_q) - 4'd1;
  assign beat_inc    = (beats_q == 16'hFFFF) ? beats_q : beats_q + 16'd1;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    beats_d = beats_q;
    case (state_q)
      CPU_OWN: begin
        if (!bus_pause && !cpu_lock && any_valid) begin
          state_d = HANDOFF;
          ch_d    = any_ch;
          cnt_d   = HCNT_INIT;
        end
      end
      HANDOFF: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else if (!bus_pause) begin
          if (any_valid) begin
            state_d = DMA_XFER;
            ch_d    = any_ch;
          end else begin
            state_d = RETURN;
            cnt_d   = RCNT_INIT;
          end
        end
      end
      DMA_XFER: begin
        if (!bus_pause) begin
          beats_d = beat_inc;
          if (dma_last[ch_q] || !dma_req[ch_q]) begin
            if (rel_valid) begin
              ch_d = rel_ch;
            end else begin
              state_d = RETURN;
              cnt_d   = RCNT_INIT;
            end
          end else if ((PREEMPT != 0) && |(dma_req & higher_mask)) begin
            ch_d = any_ch;
          end else if ((CPU_SLOT != 0) && (beat_inc == SLOT_LEN)) begin
            state_d = RETURN;
            cnt_d   = RCNT_INIT;
          end
        end
      end
      RETURN: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = CPU_OWN;
          beats_d = '0;
        end
      end
      default: state_d = CPU_OWN;
    endcase
    grant_d = (state_d == DMA_XFER) ? ch_onehot(ch_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= CPU_OWN;
      ch_q    <= '0;
      cnt_q   <= '0;
      beats_q <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      beats_q <= beats_d;
      grant_q <= grant_d;
    end
  end

  always_comb begin
    sel = '{addr: cpu_addr, wdata: cpu_wdata, size: cpu_size, write: cpu_write};
    if (state_q == DMA_XFER) begin
      sel = '{addr: dma_addr[ch_q], wdata: dma_wdata[ch_q],
              size: dma_size[ch_q], write: dma_write[ch_q]};
    end
  end

  assign bus_valid  = (state_q == CPU_OWN) || (state_q == DMA_XFER);
  assign bus_addr   = sel.addr;
  assign bus_wdata  = sel.wdata;
  assign bus_size   = sel.size;
  assign bus_write  = bus_valid & sel.write;
  assign dma_grant  = grant_q;
  assign cpu_stall  = (state_q != CPU_OWN);
  assign dma_active = (state_q != CPU_OWN);
  assign dma_beats  = beats_q;

endmodule

// File: doc/gba_bus_arbiter.md
Name: gba_bus_arbiter

Overview:
- Owns the shared system bus (addr/wdata/size/write) between the CPU and the four DMA channels.
- Fixed priority: DMA0 > DMA1 > DMA2 > DMA3 > CPU.
- Ownership changes only at beat boundaries (cycles where bus_pause = 0).
- Generates CPU stall, per-channel grants and the dma_active flag; bus_rdata fans out unmuxed from memory.

Parameters:
- HANDOFF_CYCLES, 2: idle cycles inserted when the bus moves CPU -> DMA.
- RETURN_CYCLES, 2: idle cycles inserted when the bus moves DMA -> CPU.
- PREEMPT, 1: 1 = a higher-priority channel may take the bus mid-burst at a beat boundary.
- CPU_SLOT, 0: if nonzero, after this many consecutive DMA beats the CPU gets one return window; 0 disables.

Ports:
- clk  in  1  system clock (gba_clk domain)
- rst_b  in  1  asynchronous active-low reset
- cpu_addr  in  32  CPU address
- cpu_wdata  in  32  CPU write data
- cpu_size  in  2  CPU access size
- cpu_write  in  1  CPU write strobe
- cpu_lock  in  1  CPU atomic sequence (SWP); blocks arbitration while high
- dma_req  in  4  per-channel bus request
- dma_last  in  4  current beat is the channel's final beat
- dma_addr  in  4x32  per-channel address
- dma_wdata  in  4x32  per-channel write data
- dma_size  in  4x2  per-channel size
- dma_write  in  4  per-channel write strobe
- bus_pause  in  1  memory wait; the beat is incomplete while high
- bus_addr  out  32  muxed address
- bus_wdata  out  32  muxed write data
- bus_size  out  2  muxed size
- bus_write  out  1  muxed write, gated by bus_valid
- bus_valid  out  1  a beat is presented this cycle
- dma_grant  out  4  one-hot grant, registered
- cpu_stall  out  1  CPU must hold state
- dma_active  out  1  any DMA owns or is acquiring the bus
- dma_beats  out  16  consecutive DMA beat counter (debug and LED visibility)

Behaviour:
- Reset (rst_b low, asynchronous):
  - state = CPU_OWN; dma_grant = 0; cpu_stall = 0; dma_active = 0; dma_beats = 0.
  - bus_valid = 1 with CPU fields selected.
  - Reset mid-burst aborts the burst; no handback cycles are inserted.
- States: CPU_OWN, HANDOFF, DMA_XFER, RETURN.
- CPU_OWN:
  - Bus carries the CPU fields; bus_valid = 1.
  - When bus_pause = 0, cpu_lock = 0 and dma_req != 0: latch ch = lowest-index set bit, go to HANDOFF, load hcnt = HANDOFF_CYCLES-1.
  - If cpu_lock = 1, requests wait; they are never dropped.
- HANDOFF:
  - bus_valid = 0; bus_write = 0; cpu_stall = 1; dma_active = 1.
  - hcnt decrements each cycle. At 0, go to DMA_XFER with dma_grant = onehot(ch).
  - The channel is re-evaluated at exit: a higher-priority request that arrived during HANDOFF wins.
  - If dma_req = 0 at exit, go to RETURN.
- DMA_XFER:
  - Bus carries channel ch's fields; bus_valid = 1; cpu_stall = 1.
  - A beat completes on any cycle with bus_pause = 0; dma_beats increments then, saturating at 16'hFFFF.
  - On a completed beat, in priority order:
    - (a) dma_last[ch] = 1 or dma_req[ch] = 0: release ch. Pick the next requester excluding ch this cycle. If one exists, switch the grant next cycle with no idle cycles; otherwise go to RETURN.
    - (b) PREEMPT = 1 and a higher-priority req is set: switch the grant next cycle. ch's request stays pending.
    - (c) CPU_SLOT != 0 and dma_beats == CPU_SLOT: go to RETURN; pending DMA re-arbitrates from CPU_OWN.
- RETURN:
  - bus_valid = 0; cpu_stall = 1; dma_grant = 0.
  - Count RETURN_CYCLES, then go to CPU_OWN with cpu_stall = 0, dma_active = 0, dma_beats = 0.
  - A new request during RETURN is honoured only from CPU_OWN.
- Grant timing: the grant never changes while bus_pause = 1. Outputs are combinational muxes off registered state.
- Simultaneous events: a request arriving on the same cycle as dma_last of another channel is seen by the release arbitration in (a).
- Latency: CPU -> DMA first beat is HANDOFF_CYCLES+1 cycles after the request is sampled. DMA -> CPU is RETURN_CYCLES cycles.

Decomposition:
- Package gba_bus_pkg:
  - arb_state_t enum {CPU_OWN, HANDOFF, DMA_XFER, RETURN}.
  - dma_ch_t (2 bits).
  - NUM_DMA_CH = 4.
  - bus_req_t struct {addr, wdata, size, write}.
- Sub-module dma_prio_enc: 4-bit request plus 4-bit exclude mask -> valid flag and channel index, lowest index wins.

Test Plan:
1. Idle: dma_req = 0 for 20 cycles -> bus mirrors cpu_addr each cycle; cpu_stall = 0; dma_grant = 0.
2. Single burst: dma_req[3] = 1 at t0, 4 beats, dma_last on beat 4, bus_pause = 0 -> cpu_stall rises t0+1, grant 4'b1000 at t0+3, 4 beats on bus, RETURN 2 cycles, CPU resumes at t0+9, dma_beats = 4 before clear.
3. Preemption: ch2 bursting, dma_req[0] asserted with bus_pause = 1 for 3 cycles -> grant holds 4'b0100 until pause drops, then 4'b0001 next cycle with no idle cycles; ch2 resumes after ch0's last beat.
4. cpu_lock: cpu_lock = 1 for 5 cycles with dma_req[1] = 1 -> no HANDOFF until lock drops, then the normal handoff sequence.
5. Reset mid-XFER: rst_b low during ch1 beat -> immediately dma_grant = 0, cpu_stall = 0, bus_valid = 1 with CPU fields, state = CPU_OWN.
6. CPU_SLOT = 8: dma_req[2] held with no dma_last -> after 8 beats, RETURN (2 cycles), one CPU_OWN cycle, then HANDOFF back to ch2.
